// File: rtl/store_align_unit.sv
`default_nettype none
// =============================================================================
// store_align_unit : places right-aligned store data onto the memory bus lanes,
// splitting or rejecting stores that cross a bus word.            Rev 1.0
// =============================================================================
module store_align_unit #(
  parameter int DATA_W           = 64,
  parameter int ADDR_W           = 64,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_memop,
  input  logic [63:0]         req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                done,
  output logic                err
);

  localparam int NB     = DATA_W / 8;
  localparam int LOG_NB = $clog2(NB);
  localparam int W2     = 2 * DATA_W;
  localparam int M2     = 2 * NB;

  localparam logic [2:0] MEM_B = 3'd0;
  localparam logic [2:0] MEM_H = 3'd1;
  localparam logic [2:0] MEM_W = 3'd2;
  localparam logic [2:0] MEM_D = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [W2-1:0]     wdata_q, wdata_d;
  logic [M2-1:0]     wmask_q, wmask_d;
  logic              cross_q, cross_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [3:0]        req_size;
  logic [LOG_NB-1:0] req_off;
  logic [63:0]       req_trunc;
  logic [W2-1:0]     req_shift;
  logic [M2-1:0]     req_mask;
  logic [4:0]        req_end;
  logic              req_cross;
  logic              req_bad;

  always_comb begin : decode
    req_size  = 4'd0;
    req_trunc = '0;
    case (req_memop)
      MEM_B:   req_size = 4'd1;
      MEM_H:   req_size = 4'd2;
      MEM_W:   req_size = 4'd4;
      MEM_D:   req_size = 4'd8;
      default: req_size = 4'd0;
    endcase
    req_off = req_addr[LOG_NB-1:0];
    for (int i = 0; i < 8; i++) begin
      req_trunc[i*8 +: 8] = (4'(i) < req_size) ? req_wdata[i*8 +: 8] : 8'h00;
    end
    // Double-width lanes: bytes spilling past the bus word land in the upper half.
    req_shift = W2'(req_trunc) << {req_off, 3'b000};
    req_mask  = M2'(((16'd1 << req_size) - 16'd1) << req_off);
    req_end   = 5'(req_off) + 5'(req_size);
    req_cross = req_end > 5'(NB);
    req_bad   = (req_size == 4'd0) || (req_size > 4'(NB)) ||
                (req_cross && !SPLIT_MISALIGNED);
  end

  always_comb begin : next_state
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cross_d = cross_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = LOW;
            addr_d  = {req_addr[ADDR_W-1:LOG_NB], {LOG_NB{1'b0}}};
            wdata_d = req_shift;
            wmask_d = req_mask;
            cross_d = req_cross;
          end
        end
      end
      LOW: begin
        if (mem_ready) begin
          if (cross_q) begin
            state_d = HIGH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      HIGH: begin
        if (mem_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cross_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cross_q <= cross_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin : beat_out
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    case (state_q)
      LOW: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q[DATA_W-1:0];
        mem_wmask = wmask_q[NB-1:0];
      end
      HIGH: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q + ADDR_W'(NB);
        mem_wdata = wdata_q[W2-1:DATA_W];
        mem_wmask = wmask_q[M2-1:NB];
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_store_align_unit.sv
`default_nettype none
// =============================================================================
// tb_store_align_unit : directed and randomized bench for store_align_unit,
// checked against a byte-level store model.                         Rev 1.0
// =============================================================================
module tb_store_align_unit;

  localparam logic [2:0] MEM_B = 3'd0;
  localparam logic [2:0] MEM_H = 3'd1;
  localparam logic [2:0] MEM_W = 3'd2;
  localparam logic [2:0] MEM_D = 3'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        req_valid, req_ready, mem_valid, mem_ready, done, err;
  logic [63:0] req_addr, req_wdata, mem_addr, mem_wdata;
  logic [2:0]  req_memop;
  logic [7:0]  mem_wmask;

  store_align_unit #(.DATA_W(64), .ADDR_W(64), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_memop(req_memop), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .done(done), .err(err)
  );

  // Auxiliary configurations share one request stream.
  logic        a_valid, a_mem_ready;
  logic [63:0] a_addr, a_wdata;
  logic [2:0]  a_memop;

  logic        ns_ready, ns_mem_valid, ns_done, ns_err;
  logic [63:0] ns_mem_addr, ns_mem_wdata;
  logic [7:0]  ns_mem_wmask;

  store_align_unit #(.DATA_W(64), .ADDR_W(64), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(ns_ready),
    .req_addr(a_addr), .req_memop(a_memop), .req_wdata(a_wdata),
    .mem_valid(ns_mem_valid), .mem_ready(a_mem_ready), .mem_addr(ns_mem_addr),
    .mem_wdata(ns_mem_wdata), .mem_wmask(ns_mem_wmask), .done(ns_done), .err(ns_err)
  );

  logic        n32_ready, n32_mem_valid, n32_done, n32_err;
  logic [31:0] n32_mem_addr, n32_mem_wdata;
  logic [3:0]  n32_mem_wmask;

  store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut_32 (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(n32_ready),
    .req_addr(a_addr[31:0]), .req_memop(a_memop), .req_wdata(a_wdata),
    .mem_valid(n32_mem_valid), .mem_ready(a_mem_ready), .mem_addr(n32_mem_addr),
    .mem_wdata(n32_mem_wdata), .mem_wmask(n32_mem_wmask), .done(n32_done), .err(n32_err)
  );

  // Byte-by-byte model: each store byte goes to address addr+k, i.e. to bus
  // word floor((addr+k)/nb) at lane (addr+k) mod nb.
  task automatic ref_store(input logic [63:0] addr, input logic [2:0] op,
                           input logic [63:0] wd, input int nb, input bit split,
                           output bit e, output int nbeat,
                           output logic [63:0] ba0, output logic [63:0] ba1,
                           output logic [63:0] d0, output logic [63:0] d1,
                           output logic [7:0] m0, output logic [7:0] m1);
    int size, beat, lane;
    logic [63:0] base, a;
    size = (op == MEM_B) ? 1 : (op == MEM_H) ? 2 : (op == MEM_W) ? 4 : (op == MEM_D) ? 8 : 0;
    base = addr - (addr % 64'(nb));
    ba0 = base; ba1 = base + 64'(nb);
    d0 = '0; d1 = '0; m0 = '0; m1 = '0; nbeat = 1;
    for (int k = 0; k < size; k++) begin
      a    = addr + 64'(k);
      beat = int'((a - base) / 64'(nb));
      lane = int'(a % 64'(nb));
      if (beat == 0) begin
        d0 = d0 | (64'(wd[k*8 +: 8]) << (lane * 8));
        m0 = m0 | (8'd1 << lane);
      end else begin
        d1 = d1 | (64'(wd[k*8 +: 8]) << (lane * 8));
        m1 = m1 | (8'd1 << lane);
        nbeat = 2;
      end
    end
    e = (size == 0) || (size > nb) || (nbeat == 2 && !split);
  endtask

  logic [63:0] obs_addr [2];
  logic [63:0] obs_data [2];
  logic [7:0]  obs_mask [2];
  int          obs_beats;
  bit          obs_err;

  // Issues one store on the main unit, stalls each beat for a random number of
  // cycles, checks hold/done timing, and records what each beat carried.
  task automatic run_store(input logic [63:0] addr, input logic [2:0] op,
                           input logic [63:0] wd, input int min_stall, input int max_stall);
    logic [63:0] sa, sd;
    logic [7:0]  sm;
    int stall;
    obs_beats = 0; obs_err = 1'b0;
    obs_addr[0] = '0; obs_addr[1] = '0; obs_data[0] = '0; obs_data[1] = '0;
    obs_mask[0] = '0; obs_mask[1] = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before_req: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_addr = addr; req_memop = op; req_wdata = wd; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    obs_err = (err === 1'b1);
    if (obs_err) begin
      checks++;
      if (mem_valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL err_no_beat: mem_valid=%b done=%b required 0 0", mem_valid, done);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || mem_valid !== 1'b0) begin
        errors++; $display("FAIL err_one_cycle: err=%b mem_valid=%b required 0 0", err, mem_valid);
      end
      return;
    end
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (mem_valid !== 1'b1) begin
        errors++; $display("FAIL beat%0d_valid: mem_valid=%b required 1", b, mem_valid);
        break;
      end
      sa = mem_addr; sd = mem_wdata; sm = mem_wmask;
      stall = $urandom_range(max_stall, min_stall);
      for (int s = 0; s < stall; s++) begin
        req_valid = 1'($urandom); req_addr = {$urandom, $urandom};
        req_memop = 3'($urandom); req_wdata = {$urandom, $urandom};
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== sa || mem_wdata !== sd || mem_wmask !== sm ||
            done !== 1'b0 || err !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: v=%b a=%h d=%h m=%h done=%b required 1 %h %h %h 0",
                   mem_valid, mem_addr, mem_wdata, mem_wmask, done, sa, sd, sm);
        end
      end
      mem_ready = 1'b1;
      obs_addr[b] = sa; obs_data[b] = sd; obs_mask[b] = sm; obs_beats = b + 1;
      @(negedge clk);
      mem_ready = 1'b0; req_valid = 1'b0;
      if (b == 0 && mem_valid === 1'b1 && done !== 1'b1) continue;
      checks++;
      if (done !== 1'b1 || req_ready !== 1'b1 || mem_valid !== 1'b0 ||
          mem_wdata !== 64'd0 || mem_wmask !== 8'd0) begin
        errors++;
        $display("FAIL done_pulse: done=%b ready=%b v=%b d=%h m=%h required 1 1 0 0 0",
                 done, req_ready, mem_valid, mem_wdata, mem_wmask);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL done_one_cycle: done=%b required 0", done);
      end
      break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_memop = '0; req_wdata = '0; mem_ready = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_memop = '0; a_wdata = '0; a_mem_ready = 1'b1;
    #12;
    checks++;
    if (mem_valid !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_wmask !== 8'd0 ||
        done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b a=%h d=%h m=%h done=%b err=%b required all 0",
               mem_valid, mem_addr, mem_wdata, mem_wmask, done, err);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset: ready=%b v=%b required 1 0", req_ready, mem_valid);
    end
  endtask

  task automatic test_directed;
    run_store(64'h1004, MEM_W, 64'hDEADBEEF12345678, 0, 0);
    checks++;
    if (obs_err || obs_beats != 1 || obs_addr[0] !== 64'h1000 ||
        obs_data[0] !== 64'h1234567800000000 || obs_mask[0] !== 8'hF0) begin
      errors++;
      $display("FAIL word_aligned: err=%b beats=%0d a=%h d=%h m=%h required 0 1 1000 1234567800000000 f0",
               obs_err, obs_beats, obs_addr[0], obs_data[0], obs_mask[0]);
    end
    run_store(64'h1003, MEM_D, 64'h1122334455667788, 1, 2);
    checks++;
    if (obs_err || obs_beats != 2 || obs_addr[0] !== 64'h1000 ||
        obs_data[0] !== 64'h4455667788000000 || obs_mask[0] !== 8'hF8) begin
      errors++;
      $display("FAIL dword_split_low: err=%b beats=%0d a=%h d=%h m=%h required 0 2 1000 4455667788000000 f8",
               obs_err, obs_beats, obs_addr[0], obs_data[0], obs_mask[0]);
    end
    checks++;
    if (obs_addr[1] !== 64'h1008 || obs_data[1] !== 64'h0000000000112233 || obs_mask[1] !== 8'h07) begin
      errors++;
      $display("FAIL dword_split_high: a=%h d=%h m=%h required 1008 0000000000112233 07",
               obs_addr[1], obs_data[1], obs_mask[1]);
    end
    run_store(64'h5, MEM_B, 64'hAB, 3, 3);
    checks++;
    if (obs_err || obs_beats != 1 || obs_addr[0] !== 64'h0 ||
        obs_data[0] !== 64'h0000AB0000000000 || obs_mask[0] !== 8'h20) begin
      errors++;
      $display("FAIL byte_stalled: err=%b beats=%0d a=%h d=%h m=%h required 0 1 0 0000ab0000000000 20",
               obs_err, obs_beats, obs_addr[0], obs_data[0], obs_mask[0]);
    end
  endtask

  task automatic test_random;
    logic [63:0] addr, wd, ba0, ba1, d0, d1;
    logic [7:0]  m0, m1;
    logic [2:0]  op;
    bit          e;
    int          nbeat, r;
    for (int i = 0; i < 300; i++) begin
      addr = {$urandom, $urandom};
      wd   = {$urandom, $urandom};
      r    = $urandom_range(9, 0);
      op   = (r < 8) ? 3'(r % 4) : 3'($urandom_range(7, 4));
      run_store(addr, op, wd, 0, 3);
      ref_store(addr, op, wd, 8, 1'b1, e, nbeat, ba0, ba1, d0, d1, m0, m1);
      checks++;
      if (obs_err != e || (!e && obs_beats != nbeat)) begin
        errors++;
        $display("FAIL rand_kind: addr=%h op=%0d err=%b beats=%0d required %b %0d",
                 addr, op, obs_err, obs_beats, e, nbeat);
      end else if (!e) begin
        checks++;
        if (obs_addr[0] !== ba0 || obs_data[0] !== d0 || obs_mask[0] !== m0) begin
          errors++;
          $display("FAIL rand_low: addr=%h op=%0d a=%h d=%h m=%h required %h %h %h",
                   addr, op, obs_addr[0], obs_data[0], obs_mask[0], ba0, d0, m0);
        end
        if (nbeat == 2) begin
          checks++;
          if (obs_addr[1] !== ba1 || obs_data[1] !== d1 || obs_mask[1] !== m1) begin
            errors++;
            $display("FAIL rand_high: addr=%h op=%0d a=%h d=%h m=%h required %h %h %h",
                     addr, op, obs_addr[1], obs_data[1], obs_mask[1], ba1, d1, m1);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ba0, ba1, d0, d1;
    logic [7:0]  m0, m1;
    bit          e;
    int          nbeat;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h40; req_memop = MEM_D; req_wdata = 64'h0102030405060708;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 64'h40 || req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first_beat: v=%b a=%h ready=%b required 1 40 0", mem_valid, mem_addr, req_ready);
    end
    req_addr = 64'hFFFF_0000_0000_0007; req_memop = MEM_W;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_done: done=%b ready=%b v=%b required 1 1 0", done, req_ready, mem_valid);
    end
    req_addr = 64'h2085; req_memop = MEM_H; req_wdata = {$urandom, $urandom};
    ref_store(req_addr, req_memop, req_wdata, 8, 1'b1, e, nbeat, ba0, ba1, d0, d1, m0, m1);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || done !== 1'b0 || mem_addr !== ba0 || mem_wdata !== d0 || mem_wmask !== m0) begin
      errors++;
      $display("FAIL b2b_second_beat: v=%b done=%b a=%h d=%h m=%h required 1 0 %h %h %h",
               mem_valid, done, mem_addr, mem_wdata, mem_wmask, ba0, d0, m0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second_done: done=%b v=%b required 1 0", done, mem_valid);
    end
  endtask

  task automatic test_errors;
    logic [63:0] ba0, ba1, d0, d1;
    logic [7:0]  m0, m1;
    bit          e;
    int          nbeat;
    run_store(64'h3000, 3'd5, 64'h1, 0, 0);
    checks++;
    if (!obs_err) begin
      errors++; $display("FAIL bad_memop5: err=%b required 1", obs_err);
    end
    run_store(64'h3000, 3'd7, 64'h1, 0, 0);
    checks++;
    if (!obs_err) begin
      errors++; $display("FAIL bad_memop7: err=%b required 1", obs_err);
    end
    // Crossing halfword: rejected without splitting, split on the 32-bit bus.
    a_mem_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 64'h2007; a_memop = MEM_H; a_wdata = 64'hFFFF_FFFF_FFFF_5AC3;
    ref_store(a_addr, a_memop, a_wdata, 4, 1'b1, e, nbeat, ba0, ba1, d0, d1, m0, m1);
    @(negedge clk);
    a_valid = 1'b0;
    checks++;
    if (ns_err !== 1'b1 || ns_mem_valid !== 1'b0 || ns_done !== 1'b0) begin
      errors++; $display("FAIL nosplit_err: err=%b v=%b done=%b required 1 0 0", ns_err, ns_mem_valid, ns_done);
    end
    checks++;
    if (n32_err !== 1'b0 || n32_mem_valid !== 1'b1 || n32_mem_addr !== 32'(ba0) ||
        n32_mem_wdata !== 32'(d0) || n32_mem_wmask !== 4'(m0)) begin
      errors++;
      $display("FAIL bus32_split_low: err=%b v=%b a=%h d=%h m=%h required 0 1 %h %h %h",
               n32_err, n32_mem_valid, n32_mem_addr, n32_mem_wdata, n32_mem_wmask, 32'(ba0), 32'(d0), 4'(m0));
    end
    @(negedge clk);
    checks++;
    if (ns_err !== 1'b0 || ns_mem_valid !== 1'b0 || n32_mem_addr !== 32'(ba1) || n32_mem_wmask !== 4'(m1)) begin
      errors++;
      $display("FAIL nosplit_after: err=%b v=%b a32=%h m32=%h required 0 0 %h %h",
               ns_err, ns_mem_valid, n32_mem_addr, n32_mem_wmask, 32'(ba1), 4'(m1));
    end
    repeat (3) @(negedge clk);
    // Doubleword on a 32-bit bus is always rejected; aligned on 64-bit it is fine.
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_addr = {$urandom, $urandom} & ~64'h7; a_memop = MEM_D; a_wdata = {$urandom, $urandom};
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if (n32_err !== 1'b1 || n32_mem_valid !== 1'b0 || n32_done !== 1'b0) begin
        errors++; $display("FAIL bus32_dword_err: err=%b v=%b done=%b required 1 0 0", n32_err, n32_mem_valid, n32_done);
      end
      checks++;
      if (ns_err !== 1'b0 || ns_mem_valid !== 1'b1 || ns_ready !== 1'b0 || ns_mem_addr !== a_addr ||
          ns_mem_wdata !== a_wdata || ns_mem_wmask !== 8'hFF) begin
        errors++;
        $display("FAIL nosplit_dword: err=%b v=%b a=%h d=%h m=%h required 0 1 %h %h ff",
                 ns_err, ns_mem_valid, ns_mem_addr, ns_mem_wdata, ns_mem_wmask, a_addr, a_wdata);
      end
      @(negedge clk);
      checks++;
      if (n32_err !== 1'b0 || n32_ready !== 1'b1) begin
        errors++; $display("FAIL bus32_err_pulse: err=%b ready=%b required 0 1", n32_err, n32_ready);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_store;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h1003; req_memop = MEM_D; req_wdata = 64'h1122334455667788;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 64'h1008) begin
      errors++; $display("FAIL mid_high_beat: v=%b a=%h required 1 1008", mem_valid, mem_addr);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_wmask !== 8'd0 ||
        done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: v=%b a=%h d=%h m=%h done=%b err=%b required all 0",
               mem_valid, mem_addr, mem_wdata, mem_wmask, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b done=%b required 1 0", req_ready, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL no_done_after_reset: done=%b v=%b ready=%b required 0 0 1", done, mem_valid, req_ready);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_errors;
    test_random;
    test_reset_mid_store;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
